// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types, mode presets and the axis-total helper.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    SEG_SYNC   = 2'd0,
    SEG_BACK   = 2'd1,
    SEG_ACTIVE = 2'd2,
    SEG_FRONT  = 2'd3
  } seg_t;

  // 640x480 @ 25 MHz pixel clock, negative syncs
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam logic VGA640_HS_POL = 1'b0;
  localparam logic VGA640_VS_POL = 1'b0;

  // 800x600 @ 40 MHz pixel clock, positive syncs
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam logic SVGA800_HS_POL = 1'b1;
  localparam logic SVGA800_VS_POL = 1'b1;

  function automatic int axis_total(input int sync, input int bp, input int active, input int fp);
    return sync + bp + active + fp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counts 0..TOTAL-1 on step and decodes SYNC/BACK/ACTIVE/FRONT.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int CNT_W  = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output seg_t             seg,
  output logic             wrap
);

  localparam int TOTAL = axis_total(SYNC, BP, ACTIVE, FP);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  // Boundaries may equal 2^CNT_W, so compare one bit wider than the counter
  localparam logic [CNT_W:0] B_BACK  = (CNT_W+1)'(SYNC);
  localparam logic [CNT_W:0] B_ACT   = (CNT_W+1)'(SYNC + BP);
  localparam logic [CNT_W:0] B_FRONT = (CNT_W+1)'(SYNC + BP + ACTIVE);

  generate
    if (TOTAL > (1 << CNT_W)) begin : g_bad_width
      $fatal(1, "vga_axis_counter: total %0d exceeds 2^CNT_W", TOTAL);
    end
    if (SYNC == 0 || ACTIVE == 0) begin : g_bad_seg
      $fatal(1, "vga_axis_counter: SYNC and ACTIVE must be non-zero");
    end
  endgenerate

  logic [CNT_W:0] cnt_x;
  assign cnt_x = {1'b0, cnt};
  assign wrap  = step && (cnt == LAST);

  always_comb begin
    seg = SEG_FRONT;
    if (cnt_x < B_BACK)       seg = SEG_SYNC;
    else if (cnt_x < B_ACT)   seg = SEG_BACK;
    else if (cnt_x < B_FRONT) seg = SEG_ACTIVE;
    else                      seg = SEG_FRONT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (wrap)  cnt <= '0;
    else if (step)  cnt <= cnt + CNT_W'(1);
    else            cnt <= cnt;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Two-stage VGA timing generator: HSYNC/VSYNC, coordinates, strobes and gated colour.
// Optional colour-bar source enabled by defining VGA_TEST_PATTERN_EN (adds iPATTERN).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   COLOR_W  = 4,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CNT_W    = 12
) (
  input  logic               VGA_CLOCK,
  input  logic               RESET,
  input  logic               ENABLE,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               iPATTERN,
`endif
  input  logic [COLOR_W-1:0] iVGA_R,
  input  logic [COLOR_W-1:0] iVGA_G,
  input  logic [COLOR_W-1:0] iVGA_B,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic [CNT_W-1:0]   oX,
  output logic [CNT_W-1:0]   oY,
  output logic               oACTIVE,
  output logic               oLINE_START,
  output logic               oFRAME_START
);

  localparam logic [CNT_W-1:0] H_OFF = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_OFF = CNT_W'(V_SYNC + V_BP);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  seg_t             h_seg;
  seg_t             v_seg;
  logic             h_wrap;
  logic             pix_active;
  logic [CNT_W-1:0] h_pix;
  logic [CNT_W-1:0] v_pix;
  logic             hsync1;
  logic             vsync1;

  vga_axis_counter #(
    .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP), .CNT_W(CNT_W)
  ) u_h (
    .clk(VGA_CLOCK), .reset(RESET), .clr(~ENABLE), .step(1'b1),
    .cnt(h_cnt), .seg(h_seg), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP), .CNT_W(CNT_W)
  ) u_v (
    .clk(VGA_CLOCK), .reset(RESET), .clr(~ENABLE), .step(h_wrap),
    .cnt(v_cnt), .seg(v_seg), .wrap()
  );

  assign pix_active = (h_seg == SEG_ACTIVE) && (v_seg == SEG_ACTIVE);
  assign h_pix      = h_cnt - H_OFF;
  assign v_pix      = v_cnt - V_OFF;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [CNT_W+2:0] BAR_DIV = (CNT_W+3)'(H_ACTIVE);
  logic [2:0] bar1;

  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET)           bar1 <= 3'd0;
    else if (!ENABLE)    bar1 <= 3'd0;
    else if (pix_active) bar1 <= 3'({h_pix, 3'b000} / BAR_DIV);
    else                 bar1 <= 3'd0;
  end
`endif

  // Stage 1: coordinates, active flag, strobes and sync flags from the counters
  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET || !ENABLE) begin
      oACTIVE      <= 1'b0;
      oX           <= '0;
      oY           <= '0;
      oLINE_START  <= 1'b0;
      oFRAME_START <= 1'b0;
      hsync1       <= 1'b0;
      vsync1       <= 1'b0;
    end else begin
      oACTIVE      <= pix_active;
      oX           <= pix_active ? h_pix : '0;
      oY           <= pix_active ? v_pix : '0;
      oLINE_START  <= (h_cnt == '0);
      oFRAME_START <= (h_cnt == '0) && (v_cnt == '0);
      hsync1       <= (h_seg == SEG_SYNC);
      vsync1       <= (v_seg == SEG_SYNC);
    end
  end

  // Stage 2: sync pins and colour, mutually aligned one cycle after oX/oY
  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET || !ENABLE) begin
      VGA_HS <= ~HS_POL;
      VGA_VS <= ~VS_POL;
      oVGA_R <= '0;
      oVGA_G <= '0;
      oVGA_B <= '0;
    end else begin
      VGA_HS <= hsync1 ? HS_POL : ~HS_POL;
      VGA_VS <= vsync1 ? VS_POL : ~VS_POL;
      if (!oACTIVE) begin
        oVGA_R <= '0;
        oVGA_G <= '0;
        oVGA_B <= '0;
`ifdef VGA_TEST_PATTERN_EN
      end else if (iPATTERN) begin
        oVGA_R <= {COLOR_W{bar1[2]}};
        oVGA_G <= {COLOR_W{bar1[1]}};
        oVGA_B <= {COLOR_W{bar1[0]}};
`endif
      end else begin
        oVGA_R <= iVGA_R;
        oVGA_G <= iVGA_G;
        oVGA_B <= iVGA_B;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen in a 14x8 mode, both sync polarities.
module tb_vga_timing_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic        pat;
  logic [3:0]  r_in, g_in, b_in;
  logic [3:0]  r0, g0, b0, r1, g1, b1;
  logic        hs0, vs0, hs1, vs1;
  logic [11:0] x0, y0, x1, y1;
  logic        act0, act1, ls0, ls1, fs0, fs1;

  int checks;
  int failures;

  vga_timing_gen #(
    .COLOR_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12)
  ) dut (
    .VGA_CLOCK(clk), .RESET(rst), .ENABLE(en),
`ifdef VGA_TEST_PATTERN_EN
    .iPATTERN(pat),
`endif
    .iVGA_R(r_in), .iVGA_G(g_in), .iVGA_B(b_in),
    .oVGA_R(r0), .oVGA_G(g0), .oVGA_B(b0),
    .VGA_HS(hs0), .VGA_VS(vs0), .oX(x0), .oY(y0),
    .oACTIVE(act0), .oLINE_START(ls0), .oFRAME_START(fs0)
  );

  vga_timing_gen #(
    .COLOR_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(12)
  ) dut_p (
    .VGA_CLOCK(clk), .RESET(rst), .ENABLE(en),
`ifdef VGA_TEST_PATTERN_EN
    .iPATTERN(pat),
`endif
    .iVGA_R(r_in), .iVGA_G(g_in), .iVGA_B(b_in),
    .oVGA_R(r1), .oVGA_G(g1), .oVGA_B(b1),
    .VGA_HS(hs1), .VGA_VS(vs1), .oX(x1), .oY(y1),
    .oACTIVE(act1), .oLINE_START(ls1), .oFRAME_START(fs1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int hs_low, vs_low, r_on, act_cnt, line_cnt, p_hs_high, p_vs_high;
    int fcnt, f1, f2, j;
    checks = 0; failures = 0;
    hs_low = 0; vs_low = 0; r_on = 0; act_cnt = 0; line_cnt = 0;
    p_hs_high = 0; p_vs_high = 0; fcnt = 0; f1 = 0; f2 = 0;
    rst = 1'b1; en = 1'b1; pat = 1'b0;
    r_in = 4'hF; g_in = 4'h5; b_in = 4'hA;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_hs",    32'(hs0),  32'd1);
    chk("rst_vs",    32'(vs0),  32'd1);
    chk("rst_hs_p",  32'(hs1),  32'd0);
    chk("rst_vs_p",  32'(vs1),  32'd0);
    chk("rst_r",     32'(r0),   32'd0);
    chk("rst_x",     32'(x0),   32'd0);
    chk("rst_act",   32'(act0), 32'd0);
    chk("rst_fs",    32'(fs0),  32'd0);
    rst = 1'b0;

    // Two frames of free running; edge k has the counters at k-1 behind stage 1
    for (int k = 1; k <= 230; k++) begin
      tick();
      if (fs0) begin
        fcnt++;
        if (fcnt == 1) f1 = k;
        else if (fcnt == 2) f2 = k;
      end
      if (k >= 3 && k <= 114) begin
        if (hs0 === 1'b0) hs_low++;
        if (vs0 === 1'b0) vs_low++;
        if (r0 === 4'hF) r_on++;
        if (act0 === 1'b1) act_cnt++;
        if (ls0 === 1'b1) line_cnt++;
        if (hs1 === 1'b1) p_hs_high++;
        if (vs1 === 1'b1) p_vs_high++;
      end
      if (k == 1) begin
        chk("k1_fs", 32'(fs0), 32'd1);
        chk("k1_ls", 32'(ls0), 32'd1);
        chk("k1_hs_idle", 32'(hs0), 32'd1);
      end
      if (k == 2) begin
        chk("k2_hs", 32'(hs0), 32'd0);
        chk("k2_vs", 32'(vs0), 32'd0);
        chk("k2_hs_p", 32'(hs1), 32'd1);
      end
      if (k == 47) begin
        chk("first_px_act", 32'(act0), 32'd1);
        chk("first_px_y", 32'(y0), 32'd0);
        chk("first_px_r_late", 32'(r0), 32'd0);
      end
      if (k >= 47 && k <= 54) chk("ox_run", 32'(x0), 32'(k - 47));
      if (k >= 48 && k <= 55) chk("r_run", 32'(r0), 32'hF);
      if (k == 48) begin
        chk("g_px", 32'(g0), 32'h5);
        chk("b_px", 32'(b0), 32'hA);
      end
      if (k == 55) begin
        chk("front_act", 32'(act0), 32'd0);
        chk("front_x", 32'(x0), 32'd0);
      end
      if (k == 56) chk("front_r", 32'(r0), 32'd0);
      if (k == 92) begin
        chk("last_row_x", 32'(x0), 32'd3);
        chk("last_row_y", 32'(y0), 32'd3);
      end
    end
    chk("hs_low_cnt", 32'(hs_low), 32'd24);
    chk("vs_low_cnt", 32'(vs_low), 32'd28);
    chk("r_on_cnt", 32'(r_on), 32'd32);
    chk("act_cnt", 32'(act_cnt), 32'd32);
    chk("line_cnt", 32'(line_cnt), 32'd8);
    chk("p_hs_high_cnt", 32'(p_hs_high), 32'd24);
    chk("p_vs_high_cnt", 32'(p_vs_high), 32'd28);
    chk("frame_cnt", 32'(fcnt), 32'd3);
    chk("frame_first", 32'(f1), 32'd1);
    chk("frame_second", 32'(f2), 32'd113);

    // Advance to h_cnt=9, v_cnt=3 and drop ENABLE for 5 cycles
    repeat (45) tick();
    chk("pre_drop_x", 32'(x0), 32'd4);
    chk("pre_drop_act", 32'(act0), 32'd1);
    en = 1'b0;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("gap_act", 32'(act0), 32'd0);
      chk("gap_x", 32'(x0), 32'd0);
      chk("gap_r", 32'(r0), 32'd0);
      chk("gap_hs", 32'(hs0), 32'd1);
      chk("gap_vs", 32'(vs0), 32'd1);
      chk("gap_vs_p", 32'(vs1), 32'd0);
      chk("gap_fs", 32'(fs0), 32'd0);
    end
    en = 1'b1;
    tick();
    chk("reen_fs", 32'(fs0), 32'd1);
    j = 2;
    while (j <= 200) begin
      tick();
      if (fs0 === 1'b1) break;
      j++;
    end
    chk("reen_frame_period", 32'(j - 1), 32'd112);

    // Mid-active asynchronous reset between clock edges
    repeat (49) tick();
    chk("pre_rst_r", 32'(r0), 32'hF);
    chk("pre_rst_x", 32'(x0), 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("arst_r", 32'(r0), 32'd0);
    chk("arst_g", 32'(g0), 32'd0);
    chk("arst_act", 32'(act0), 32'd0);
    chk("arst_x", 32'(x0), 32'd0);
    chk("arst_hs", 32'(hs0), 32'd1);
    chk("arst_vs", 32'(vs0), 32'd1);
    chk("arst_hs_p", 32'(hs1), 32'd0);
    #1 rst = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    pat = 1'b1;
`endif
    tick();
    chk("restart_fs", 32'(fs0), 32'd1);
    chk("restart_ls", 32'(ls0), 32'd1);
    tick();
    chk("restart_hs", 32'(hs0), 32'd0);
    chk("restart_hs_p", 32'(hs1), 32'd1);
`ifdef VGA_TEST_PATTERN_EN
    // Colour bars: column c shows bar c as {R,G,B} = c bits
    for (int rr = 3; rr <= 55; rr++) begin
      tick();
      if (rr >= 48) begin
        chk("bar_r", 32'(r0), (rr - 48) >= 4 ? 32'hF : 32'h0);
        chk("bar_g", 32'(g0), (((rr - 48) >> 1) & 1) == 1 ? 32'hF : 32'h0);
        chk("bar_b", 32'(b0), ((rr - 48) & 1) == 1 ? 32'hF : 32'h0);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
